// File: rtl/ctrl_pad_reader.sv
// ctrl_pad_reader: polls a 4021-style game controller pad and publishes
// one 8-bit active-high button frame per poll. Four-state FSM
// (IDLE -> LATCH -> READ -> DONE) is paced by a CLK_DIV-cycle tick.
// Each READ bit has a HIGH phase and a LOW phase. The bit is sampled at
// the end of the HIGH phase, once the pad has had a full tick to settle
// after its shift edge.
module ctrl_pad_reader #(
  parameter int CLK_DIV    = 64,
  parameter int POLL_TICKS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data,
  output logic [7:0] buttons,
  output logic       valid
);

  localparam int TW = $clog2(CLK_DIV);
  // Wide enough for POLL_TICKS-1 and for the 2-tick latch count.
  localparam int PW = $clog2(POLL_TICKS + 2);

  typedef enum logic [1:0] {IDLE, LATCH, READ, DONE} state_t;
  typedef enum logic {PH_HIGH, PH_LOW} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  buttons_q, buttons_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        pad_latch_q, pad_latch_d;
  logic        pad_clk_q, pad_clk_d;
  logic        valid_q, valid_d;
  logic        tick_end;

  assign tick_end = (tick_q == TW'(CLK_DIV - 1));

  // Next-state, counter, sampling and registered-output computation
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tick_d    = tick_end ? '0 : tick_q + TW'(1);
    poll_d    = poll_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    sync1_d   = pad_data;
    sync2_d   = sync1_q;

    case (state_q)
      IDLE: begin
        if (tick_end) begin
          if (poll_q == PW'(POLL_TICKS - 1)) begin
            state_d = LATCH;
            poll_d  = '0;
          end else begin
            poll_d = poll_q + PW'(1);
          end
        end
      end
      LATCH: begin
        if (tick_end) begin
          if (poll_q == PW'(1)) begin
            state_d = READ;
            phase_d = PH_HIGH;
            idx_d   = 3'd0;
            poll_d  = '0;
          end else begin
            poll_d = poll_q + PW'(1);
          end
        end
      end
      READ: begin
        if (tick_end) begin
          if (phase_q == PH_HIGH) begin
            shift_d[idx_q] = ~sync2_q;
            phase_d        = PH_LOW;
          end else if (idx_q == 3'd7) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            phase_d = PH_HIGH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        tick_d  = '0;
        poll_d  = '0;
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
      end
    endcase

    // Buttons load on the edge that enters DONE, so they change together with valid.
    if (state_d == DONE && state_q != DONE) begin
      buttons_d = shift_d;
    end

    pad_latch_d = (state_d == LATCH);
    pad_clk_d   = !(state_d == READ && phase_d == PH_LOW);
    valid_d     = (state_d == DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= PH_HIGH;
      tick_q      <= '0;
      poll_q      <= '0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      buttons_q   <= 8'h00;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      pad_latch_q <= 1'b0;
      pad_clk_q   <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      poll_q      <= poll_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      buttons_q   <= buttons_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pad_latch_q <= pad_latch_d;
      pad_clk_q   <= pad_clk_d;
      valid_q     <= valid_d;
    end
  end

  assign pad_latch = pad_latch_q;
  assign pad_clk   = pad_clk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_ctrl_pad_reader.sv
// Testbench for ctrl_pad_reader with CLK_DIV=4, POLL_TICKS=2.
// A behavioural 4021-style pad drives pad_data. Expected frames are queued
// when a pattern is applied and are consumed whenever valid pulses.
module tb_ctrl_pad_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data;
  logic [7:0] buttons;
  logic       valid;

  logic [7:0] pressed;
  logic       tie_en;
  logic       tie_val;
  logic [7:0] pad_sr;
  logic       mon_en;
  logic       rst_at_edge = 1'b0;
  logic [7:0] last_buttons;
  logic [7:0] sb[$];
  int         compared = 0;
  int         mismatched = 0;

  ctrl_pad_reader #(.CLK_DIV(4), .POLL_TICKS(2)) dut (
    .clk(clk),
    .reset(reset),
    .pad_latch(pad_latch),
    .pad_clk(pad_clk),
    .pad_data(pad_data),
    .buttons(buttons),
    .valid(valid)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Pad model: parallel load while latched, shift toward the output on pad_clk rise
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pad_sr <= ~pressed;
    else           pad_sr <= {1'b1, pad_sr[7:1]};
  end

  assign pad_data = tie_en ? tie_val : (pad_latch ? ~pressed[0] : pad_sr[0]);

  // Remember whether the DUT saw reset on the most recent edge
  always @(posedge clk) rst_at_edge <= reset;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] pat, input logic use_tie,
                               input logic tie_level, input logic [7:0] exp_pat,
                               input int frames);
    @(posedge clk);
    #1;
    pressed = pat;
    tie_en  = use_tie;
    tie_val = tie_level;
    for (int i = 0; i < frames; i++) sb.push_back(exp_pat);
  endtask

  task automatic waitFrames(input int n);
    for (int f = 0; f < n; f++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (valid !== 1'b1 && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      checkOutput("frame_arrived", valid, 1'b1);
    end
  endtask

  task automatic measureFrame();
    int   guard;
    int   latch_len;
    int   cyc;
    int   n_low;
    int   low_len;
    int   last_start;
    logic prev_clk;
    guard = 0;
    while (pad_latch !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("latch_seen", pad_latch, 1'b1);
    latch_len = 0;
    while (pad_latch === 1'b1 && latch_len < 50) begin
      latch_len++;
      @(negedge clk);
    end
    checkOutput("latch_len", latch_len, 8);
    n_low = 0; low_len = 0; last_start = 0; cyc = 0; prev_clk = 1'b1;
    while (cyc < 200) begin
      if (pad_clk === 1'b0) begin
        if (prev_clk === 1'b1) begin
          if (n_low > 0) checkOutput("low_spacing", cyc - last_start, 8);
          last_start = cyc;
          n_low++;
          low_len = 0;
        end
        low_len++;
      end else if (prev_clk === 1'b0) begin
        checkOutput("low_width", low_len, 4);
      end
      prev_clk = pad_clk;
      if (valid === 1'b1) break;
      @(negedge clk);
      cyc++;
    end
    checkOutput("low_count", n_low, 8);
    checkOutput("frame_end_valid", valid, 1'b1);
  endtask

  // Continuous monitor: reset values, latch/clk exclusion, scoreboard and buttons hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_at_edge) begin
        checkOutput("rst_buttons", buttons, 8'h00);
        checkOutput("rst_valid", valid, 1'b0);
        checkOutput("rst_latch", pad_latch, 1'b0);
        checkOutput("rst_padclk", pad_clk, 1'b1);
        last_buttons = 8'h00;
      end else begin
        checkOutput("latch_clk_excl", pad_latch & ~pad_clk, 1'b0);
        if (valid === 1'b1) begin
          checkOutput("sb_nonempty", sb.size() != 0, 1'b1);
          if (sb.size() != 0) checkOutput("frame_buttons", buttons, sb.pop_front());
        end else begin
          checkOutput("buttons_hold", buttons, last_buttons);
        end
        last_buttons = buttons;
      end
    end
  end

  // Directed sequence of test steps
  initial begin
    int n;
    int guard;
    logic prev;
    reset = 1'b1; tie_en = 1'b0; tie_val = 1'b1; pressed = 8'h00; mon_en = 1'b0;
    last_buttons = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("init_latch", pad_latch, 1'b0);
    checkOutput("init_padclk", pad_clk, 1'b1);
    checkOutput("init_buttons", buttons, 8'h00);
    checkOutput("init_valid", valid, 1'b0);

    applyStimulus(8'hA5, 1'b0, 1'b0, 8'hA5, 2);
    mon_en = 1'b1;
    reset  = 1'b0;
    n = 0;
    while (pad_latch !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("first_latch_delay", n, 8);
    waitFrames(1);
    measureFrame();

    applyStimulus(8'h01, 1'b0, 1'b0, 8'h01, 1);
    waitFrames(1);
    applyStimulus(8'h80, 1'b0, 1'b0, 8'h80, 1);
    waitFrames(1);

    applyStimulus(8'h3C, 1'b0, 1'b0, 8'h3C, 1);
    guard = 0;
    while (pad_latch !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    n = 0; prev = 1'b1;
    while (n < 5 && guard < 300) begin
      @(negedge clk);
      if (pad_clk === 1'b0 && prev === 1'b1) n++;
      prev = pad_clk;
      guard++;
    end
    checkOutput("abort_at_bit4", n, 5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    waitFrames(1);

    applyStimulus(8'h00, 1'b1, 1'b0, 8'hFF, 2);
    waitFrames(1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < 200);
    checkOutput("valid_period", n, 81);

    applyStimulus(8'h00, 1'b1, 1'b1, 8'h00, 1);
    waitFrames(1);

    @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ctrl_pad_reader.md
CTRL_PAD_READER -- requirements
Module: ctrl_pad_reader

Interface
REQ-001 Parameter CLK_DIV, default 64: clk cycles per tick; legal range >= 4.
REQ-002 Parameter POLL_TICKS, default 1000: idle ticks between polls; legal range >= 1.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pad_latch  output  1  controller latch/strobe; high loads the pad shift register.
REQ-006 pad_clk  output  1  controller clock; idles high; the pad shifts on the rising edge.
REQ-007 pad_data  input  1  controller serial data, active-low (0 = pressed); asynchronous to clk.
REQ-008 buttons  output  8  active-high button state, published per frame.
- bit order: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
REQ-009 valid  output  1  one-cycle pulse marking the cycle buttons updates.

Function
REQ-010 pad_data SHALL pass through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-011 A tick counter SHALL count 0..CLK_DIV-1 and restart at 0 on every state or phase entry.
- A tick SHALL end when the count equals CLK_DIV-1.
REQ-012 The FSM SHALL have exactly four states: IDLE, LATCH, READ, DONE.
REQ-013 IDLE: pad_latch=0, pad_clk=1.
- SHALL remain for POLL_TICKS ticks (POLL_TICKS*CLK_DIV cycles), then enter LATCH.
REQ-014 LATCH: pad_latch=1, pad_clk=1.
- SHALL last exactly 2 ticks, then enter READ with bit index 0 in phase HIGH.
REQ-015 READ phase HIGH: pad_latch=0, pad_clk=1, lasting 1 tick.
- On the last cycle of the tick, SHALL store the inverted synchronized pad_data into shift[index], then enter phase LOW.
REQ-016 READ phase LOW: pad_clk=0, lasting 1 tick.
- For index 0..6: SHALL then return to phase HIGH with index+1; pad_clk SHALL rise at that transition.
- For index 7: SHALL then enter DONE.
REQ-017 READ SHALL produce exactly 8 pad_clk low pulses, each CLK_DIV cycles wide.
- Total READ duration SHALL be 16*CLK_DIV cycles.
REQ-018 DONE SHALL last exactly 1 cycle: buttons <= shift, valid=1, pad_clk=1, then IDLE.
REQ-019 valid SHALL be 0 in every cycle other than the DONE cycle.
REQ-020 buttons SHALL change only in the DONE cycle; partial frames SHALL never reach buttons.
REQ-021 Consecutive valid pulses SHALL be exactly (POLL_TICKS+18)*CLK_DIV+1 cycles apart.
REQ-022 pad_latch and pad_clk SHALL be registered outputs, glitch-free.
- pad_clk SHALL never be low while pad_latch is high.
REQ-023 A disconnected pad (pad_data constantly 1) SHALL yield buttons=8'h00 with normal valid cadence.

Reset
REQ-024 While reset=1, at each clk edge, the block SHALL set:
- state=IDLE, tick and poll counters=0, bit index=0, shift=0;
- pad_latch=0, pad_clk=1, buttons=8'h00, valid=0;
- synchronizer flops=1.
REQ-025 Reset SHALL take precedence over every state transition.
- Reset asserted mid-LATCH or mid-READ SHALL abort the frame with no valid pulse; buttons SHALL be 8'h00.
REQ-026 After reset deasserts, the first LATCH SHALL begin POLL_TICKS*CLK_DIV cycles later.

Verification (CLK_DIV=4, POLL_TICKS=2; bench models a 4021-style pad: load on latch high, shift on pad_clk rise, output active-low, 2-cycle data delay)
REQ-027 Reset: hold reset 3 cycles -> pad_latch=0, pad_clk=1, buttons=8'h00, valid=0.
- First pad_latch rise SHALL occur 8 cycles after reset deasserts.
REQ-028 Pad pressed pattern 8'hA5 (A, Select, Down, Right... per bit map) -> one valid pulse with buttons=8'hA5.
- buttons SHALL stay stable until the next DONE.
REQ-029 Waveform check on one frame:
- pad_latch high exactly 8 cycles;
- then 8 pad_clk low pulses, each 4 cycles, spaced 8 cycles apart;
- no pad_clk low while latched.
REQ-030 Constant input:
- pad_data tied 0 -> buttons=8'hFF on two consecutive frames, valid pulses exactly 81 cycles apart.
- pad_data tied 1 -> buttons=8'h00.
REQ-031 Reset during bit 4 of a frame whose pattern is 8'h3C:
- next cycle at reset values, no valid pulse, buttons=8'h00;
- after release, the following full frame SHALL publish 8'h3C.
REQ-032 Pattern change between frames, 8'h01 then 8'h80:
- buttons=8'h01 until the second DONE cycle, then 8'h80;
- no intermediate value visible.
